// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one system bus between fetch (M0) and LSU (M1); hold-time limiter; BUS_ARB_RR_EN enables round-robin IDLE arbitration
module bus_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic        i_CLK,
   input  logic        i_RSTn,
   input  logic        i_M0_REQ,
   input  logic [31:0] i_M0_ADDR,
   input  logic        i_M0_RE,
   output logic        o_M0_GNT,
   output logic        o_M0_ACK,
   input  logic        i_M1_REQ,
   input  logic [31:0] i_M1_ADDR,
   input  logic [31:0] i_M1_WDATA,
   input  logic        i_M1_WE,
   input  logic        i_M1_RE,
   input  logic [1:0]  i_M1_HB,
   output logic        o_M1_GNT,
   output logic        o_M1_ACK,
   output logic [31:0] o_BUS_ADDR,
   output logic [31:0] o_BUS_WDATA,
   output logic        o_BUS_WE,
   output logic        o_BUS_RE,
   output logic [1:0]  o_BUS_HB,
   input  logic        i_BUS_ACK,
   input  logic [31:0] i_BUS_RDATA,
   output logic [31:0] o_M_RDATA
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] hold_cnt, hold_nx;
   logic own0, own1, other_req, at_limit, pick1;
   assign own0      = state == OWN0;
   assign own1      = state == OWN1;
   assign other_req = (own0 & i_M1_REQ) | (own1 & i_M0_REQ);
   assign at_limit  = hold_cnt == CNT_W'(MAX_HOLD - 1);
`ifdef BUS_ARB_RR_EN
   logic last;
   // remember the most recent owner so contended IDLE arbitration alternates
   always_ff @(posedge i_CLK)
      if (!i_RSTn) last <= 1'b0;
      else if (state_nx == OWN0 && !own0) last <= 1'b0;
      else if (state_nx == OWN1 && !own1) last <= 1'b1;
   assign pick1 = i_M1_REQ && !(i_M0_REQ && last);
`else
   assign pick1 = i_M1_REQ;
`endif
   // next owner: handoff on REQ drop, preempt only on an ack'd boundary at the hold limit
   always_comb begin
      state_nx = IDLE;
      if (own0)
         state_nx = !i_M0_REQ ? (i_M1_REQ ? OWN1 : IDLE)
                  : (i_M1_REQ && i_BUS_ACK && at_limit) ? OWN1 : OWN0;
      else if (own1)
         state_nx = !i_M1_REQ ? (i_M0_REQ ? OWN0 : IDLE)
                  : (i_M0_REQ && i_BUS_ACK && at_limit) ? OWN0 : OWN1;
      else
         state_nx = pick1 ? OWN1 : i_M0_REQ ? OWN0 : IDLE;
   end
   // count acks the owner completes while the other master waits; saturating
   always_comb begin
      hold_nx = hold_cnt;
      if (state_nx != state || !other_req) hold_nx = '0;
      else if (i_BUS_ACK && hold_cnt != CNT_W'(MAX_HOLD)) hold_nx = hold_cnt + 1'b1;
   end
   // grant state and hold counter registers
   always_ff @(posedge i_CLK)
      if (!i_RSTn) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         hold_cnt <= hold_nx;
      end
   assign o_M0_GNT    = own0;
   assign o_M1_GNT    = own1;
   assign o_M0_ACK    = i_BUS_ACK & own0;
   assign o_M1_ACK    = i_BUS_ACK & own1;
   assign o_BUS_ADDR  = own0 ? i_M0_ADDR : own1 ? i_M1_ADDR : 32'h0;
   assign o_BUS_WDATA = own1 ? i_M1_WDATA : 32'h0;
   assign o_BUS_RE    = own0 ? (i_M0_RE & i_M0_REQ) : own1 ? (i_M1_RE & i_M1_REQ) : 1'b0;
   assign o_BUS_WE    = own1 & i_M1_WE & i_M1_REQ;
   assign o_BUS_HB    = own0 ? 2'b10 : own1 ? i_M1_HB : 2'b00;
   assign o_M_RDATA   = i_BUS_RDATA;
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single system bus between two masters: M0 = instruction fetch and M1 = load/store unit (LSU).
- Sits between the core's master ports and the memory/peripheral interconnect.
- Owns a registered grant FSM, the master-to-slave request/data mux, ack routing, and a hold-time limiter.
- Prevents one master from starving the other during long burst sequences.

Parameters:
- MAX_HOLD, 16: consecutive ack'd transfers the owner may complete while the other master waits; range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- i_CLK  in  1  system clock, rising edge
- i_RSTn  in  1  synchronous active-low reset
- i_M0_REQ  in  1  fetch requests bus
- i_M0_ADDR  in  32  fetch address
- i_M0_RE  in  1  fetch read enable
- o_M0_GNT  out  1  fetch owns bus
- o_M0_ACK  out  1  fetch transfer complete
- i_M1_REQ  in  1  LSU requests bus
- i_M1_ADDR  in  32  LSU address
- i_M1_WDATA  in  32  LSU write data
- i_M1_WE  in  1  LSU write enable
- i_M1_RE  in  1  LSU read enable
- i_M1_HB  in  2  LSU size: 00 byte, 01 half, 10 word
- o_M1_GNT  out  1  LSU owns bus
- o_M1_ACK  out  1  LSU transfer complete
- o_BUS_ADDR  out  32  slave address
- o_BUS_WDATA  out  32  slave write data
- o_BUS_WE  out  1  slave write strobe
- o_BUS_RE  out  1  slave read strobe
- o_BUS_HB  out  2  slave transfer size
- i_BUS_ACK  in  1  slave completes current transfer
- i_BUS_RDATA  in  32  slave read data
- o_M_RDATA  out  32  read data, broadcast to both masters

Behaviour:
- Reset: synchronous, sampled on the i_CLK rising edge while i_RSTn=0.
  - State goes to IDLE; hold counter clears to 0; round-robin pointer (if built) clears to 0.
  - All outputs are 0 in the cycle after the reset edge. o_M_RDATA follows i_BUS_RDATA combinationally.
- States: IDLE, OWN0, OWN1. GNT outputs are decoded from registered state only.
- IDLE:
  - M1 requesting -> OWN1, else M0 requesting -> OWN0 (fixed priority).
  - Grant appears the cycle after REQ is first sampled high.
- OWNx, REQx dropped:
  - Other master requesting -> direct handoff to OWNy on the same edge, no idle cycle.
  - Otherwise -> IDLE.
- OWNx, REQx held:
  - Stay in OWNx.
  - Exception: preempt to OWNy when the other master is requesting, i_BUS_ACK=1 this cycle, and the hold counter equals MAX_HOLD-1.
  - Preemption happens only on an ack'd transfer boundary, never mid-transfer.
- Hold counter:
  - Increments on each i_BUS_ACK while in OWNx and the other REQ=1.
  - Clears on any state change, or when the other REQ=0.
  - Saturates; never wraps.
- Slave mux:
  - In OWN0: o_BUS_ADDR=i_M0_ADDR, o_BUS_RE=i_M0_RE, o_BUS_WE=0, o_BUS_WDATA=0, o_BUS_HB=2'b10.
  - In OWN1: all bus outputs come from the M1 inputs.
  - In IDLE: all bus outputs are 0.
  - RE/WE are additionally gated by the owner's REQ, so dropping REQ removes the strobe the same cycle.
- Ack routing: o_Mx_ACK = i_BUS_ACK & (state==OWNx). An ack arriving in IDLE is discarded.
- Masters:
  - Must hold REQ and their address/data stable from REQ until their own ACK.
  - A master that loses GNT by preemption keeps REQ high and waits for re-grant.
  - The arbiter does not buffer data.
- Simultaneous first requests: M1 wins; with MAX_HOLD=1, M0 gets the bus after M1's first ack.
- Both REQ dropping together while in OWNx -> IDLE.
- Reset asserted mid-transfer: the in-flight transfer is abandoned; a slave ack in the following cycle is discarded.

Optional Feature:
- Macro: BUS_ARB_RR_EN.
- Defined:
  - A 1-bit last-owner pointer is updated on every entry to OWN0/OWN1.
  - IDLE arbitration and simultaneous-request resolution favour the master that did not own last. Direct handoff rules are unchanged.
- Undefined: fixed priority M1 > M0, no pointer register.

Test Plan:
- M0 REQ alone at cycle 0; slave ack at cycle 2 -> o_M0_GNT=1 at cycle 1; o_M0_ACK=1 at cycle 2; o_BUS_ADDR=i_M0_ADDR, o_BUS_HB=2'b10.
- M0 and M1 REQ both rise at cycle 0 -> o_M1_GNT=1 at cycle 1; o_M0_GNT=0 until M1 drops REQ; M0 granted on the same edge M1 drops (handoff, no IDLE cycle).
- MAX_HOLD=4; M1 holds REQ and slave acks every cycle while M0 waits -> after M1's 4th ack, o_M1_GNT=0 and o_M0_GNT=1 the next cycle.
- M1 write 0xDEADBEEF to 0x1000_0004, HB=01 -> o_BUS_WE=1, o_BUS_WDATA=0xDEADBEEF, o_BUS_HB=01 while ACK is low; o_M1_ACK pulses for 1 cycle; o_M0_ACK stays 0.
- i_RSTn=0 for one cycle during OWN1 with ack pending -> all GNT/WE/RE are 0 the next cycle; an ack in that cycle produces no o_Mx_ACK.
- BUS_ARB_RR_EN defined; M1 completes a transfer, then both REQ rise together -> M0 is granted first.
